// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - opcodes, ALUOp codes, control bundle and forwarding selects for pipe_control
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef struct packed {
        logic       alu_src;
        logic       reg_dst;
        logic [2:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       beq;
        logic       bne;
        logic       jump;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Instructions whose rt field is a source operand (others use rt as a destination or ignore it).
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode to control-bundle table
module ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_t      ctrl,
    output logic       illegal
);

    always_comb begin
        ctrl    = CTRL_NOP;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.alu_op     = ALU_FUNCT;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            OP_J:   ctrl.jump = 1'b1;
            OP_BEQ: begin
                ctrl.alu_op = ALU_SUB;
                ctrl.beq    = 1'b1;
            end
            OP_BNE: begin
                ctrl.alu_op = ALU_SUB;
                ctrl.bne    = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                case (opcode)
                    OP_ANDI: ctrl.alu_op = ALU_AND;
                    OP_ORI:  ctrl.alu_op = ALU_OR;
                    OP_SLTI: ctrl.alu_op = ALU_SLT;
                    default: ctrl.alu_op = ALU_ADD;
                endcase
            end
            OP_LW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.mem_read  = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.mem_write = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_control.sv
// rtl/pipe_control.sv - pipelined control unit: decode, ID/EX-EX/MEM-MEM/WB control, hazards, forwarding
module pipe_control
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int ALUOP_W   = 3,
    parameter int HAZARD_EN = 1,
    parameter int FWD_EN    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         id_opcode,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               ex_branch_taken,
    output logic               id_jump,
    output logic               id_illegal,
    output logic               stall,
    output logic               flush_ifid,
    output logic               ex_alu_src,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_branch_eq,
    output logic               ex_branch_neq,
    output logic [REG_AW-1:0]  ex_rs,
    output logic [REG_AW-1:0]  ex_rt,
    output logic               mem_write,
    output logic               mem_read,
    output logic               wb_mem_to_reg,
    output logic               wb_reg_write,
    output logic [REG_AW-1:0]  ex_wreg,
    output logic [REG_AW-1:0]  mem_wreg,
    output logic [REG_AW-1:0]  wb_wreg,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b
);

    ctrl_t             dec;
    logic              dec_illegal;
    logic [REG_AW-1:0] id_dst;
    logic              load_use;
    logic              bubble;

    logic ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
    logic mem_mem_to_reg, mem_reg_write;

    ctrl_decode u_decode (
        .opcode  (id_opcode),
        .ctrl    (dec),
        .illegal (dec_illegal)
    );

    always_comb begin
        id_jump    = dec.jump;
        id_illegal = dec_illegal;
        id_dst     = dec.reg_write ? (dec.reg_dst ? id_rd : id_rt) : '0;
        load_use   = ex_mem_read && (ex_wreg != '0) &&
                     ((ex_wreg == id_rs) || (reads_rt(id_opcode) && (ex_wreg == id_rt)));
        // A taken branch squashes the ID instruction anyway, so it overrides the load-use stall.
        stall      = (HAZARD_EN != 0) && load_use && !ex_branch_taken;
        flush_ifid = ex_branch_taken || dec.jump;
        bubble     = stall || ex_branch_taken;
    end

    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (FWD_EN != 0) begin
            if (mem_reg_write && (mem_wreg != '0) && (mem_wreg == ex_rs))
                fwd_a = FWD_MEM;
            else if (wb_reg_write && (wb_wreg != '0) && (wb_wreg == ex_rs))
                fwd_a = FWD_WB;
            if (mem_reg_write && (mem_wreg != '0) && (mem_wreg == ex_rt))
                fwd_b = FWD_MEM;
            else if (wb_reg_write && (wb_wreg != '0) && (wb_wreg == ex_rt))
                fwd_b = FWD_WB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_alu_src     <= 1'b0;
            ex_alu_op      <= '0;
            ex_branch_eq   <= 1'b0;
            ex_branch_neq  <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_mem_to_reg  <= 1'b0;
            ex_reg_write   <= 1'b0;
            ex_rs          <= '0;
            ex_rt          <= '0;
            ex_wreg        <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_mem_to_reg <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_wreg       <= '0;
            wb_mem_to_reg  <= 1'b0;
            wb_reg_write   <= 1'b0;
            wb_wreg        <= '0;
        end else begin
            ex_alu_src     <= bubble ? 1'b0 : dec.alu_src;
            ex_alu_op      <= bubble ? '0 : ALUOP_W'(dec.alu_op);
            ex_branch_eq   <= bubble ? 1'b0 : dec.beq;
            ex_branch_neq  <= bubble ? 1'b0 : dec.bne;
            ex_mem_read    <= bubble ? 1'b0 : dec.mem_read;
            ex_mem_write   <= bubble ? 1'b0 : dec.mem_write;
            ex_mem_to_reg  <= bubble ? 1'b0 : dec.mem_to_reg;
            ex_reg_write   <= bubble ? 1'b0 : dec.reg_write;
            ex_rs          <= bubble ? '0 : id_rs;
            ex_rt          <= bubble ? '0 : id_rt;
            ex_wreg        <= bubble ? '0 : id_dst;
            mem_read       <= ex_mem_read;
            mem_write      <= ex_mem_write;
            mem_mem_to_reg <= ex_mem_to_reg;
            mem_reg_write  <= ex_reg_write;
            mem_wreg       <= ex_wreg;
            wb_mem_to_reg  <= mem_mem_to_reg;
            wb_reg_write   <= mem_reg_write;
            wb_wreg        <= mem_wreg;
        end
    end

endmodule

// File: doc/pipe_control.md
Name: pipe_control

Overview:
- Next-generation control unit for the 5-stage pipelined CPU.
- Decodes the ID-stage opcode into a control bundle and carries it through the ID/EX, EX/MEM and MEM/WB control registers, together with the destination register number.
- Adds what the single-cycle decoder lacks: load-use stall, branch/jump flush, EX-stage forwarding selects, an extended opcode set (ori, slti), a wider ALUOp, and illegal-opcode flagging.

Parameters:
REG_AW, 5, register-number width
ALUOP_W, 3, ALUOp width (>=3)
HAZARD_EN, 1, 1 = load-use stall logic active; 0 = stall forced 0
FWD_EN, 1, 1 = forwarding selects active; 0 = fwd_a/fwd_b forced 0

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
id_opcode  in  6  opcode of instruction in ID
id_rs  in  REG_AW  rs field in ID
id_rt  in  REG_AW  rt field in ID
id_rd  in  REG_AW  rd field in ID
ex_branch_taken  in  1  datapath compare result for the branch in EX (already qualified by ex_branch_eq/ex_branch_neq)
id_jump  out  1  combinational: ID instruction is j
id_illegal  out  1  combinational: opcode not in table
stall  out  1  hold PC and IF/ID this cycle
flush_ifid  out  1  zero IF/ID this cycle
ex_alu_src, ex_alu_op[ALUOP_W], ex_branch_eq, ex_branch_neq  out  ID/EX control
ex_rs, ex_rt  out  REG_AW  registered source numbers
mem_write, mem_read  out  1  EX/MEM control
wb_mem_to_reg, wb_reg_write  out  1  MEM/WB control
ex_wreg, mem_wreg, wb_wreg  out  REG_AW  destination register per stage
fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB

Behaviour:
- Decode (combinational, ID). Fields are alu_src, reg_dst, alu_op, mem_read, mem_write, beq, bne, jump, mem_to_reg, reg_write:
  - R (000000): 0,1,010,0,0,0,0,0,1,1
  - j (000010): all 0 except jump=1
  - beq (000100): alu_op=001, beq=1, rest 0
  - bne (000101): alu_op=001, bne=1, rest 0
  - addi (001000): 1,0,000,0,0,0,0,0,1,1
  - andi (001100): 1,0,011,…,1,1
  - ori (001101): 1,0,100,…,1,1
  - slti (001010): 1,0,101,…,1,1
  - lw (100011): 1,0,000,1,0,0,0,0,0,1
  - sw (101011): 1,0,000,0,1,0,0,0,0,0
  - Any other opcode: all 0, id_illegal=1.
- mem_to_reg polarity: 1 writes the ALU result, 0 writes memory data.
- Destination: dst = reg_dst ? id_rd : id_rt. If reg_write=0, dst is forced to 0.
- Load-use (HAZARD_EN=1): stall=1 when all of the following hold:
  - ID/EX mem_read=1 and ex_wreg!=0;
  - ex_wreg==id_rs, or ex_wreg==id_rt with the ID instruction reading rt (R, beq, bne, sw).
- Bubble: on stall, ID/EX loads an all-zero bundle (wreg=0) and IF/ID/PC hold (external). Stall lasts exactly 1 cycle per hazard.
- Flush:
  - ex_branch_taken=1: flush_ifid=1, ID/EX loads a bubble, stall forced 0 (flush has priority).
  - id_jump=1 with no branch flush: flush_ifid=1; the j bundle itself enters ID/EX (harmless, no writes).
- Pipeline: each rising edge, EX/MEM <= ID/EX (mem and wb fields plus wreg), MEM/WB <= EX/MEM (wb fields plus wreg). Latency from ID to WB controls is 3 cycles.
- Forwarding (combinational on registered values; FWD_EN=1):
  - fwd_a=10 if mem_reg_write and mem_wreg!=0 and mem_wreg==ex_rs;
  - else fwd_a=01 if wb_reg_write and wb_wreg!=0 and wb_wreg==ex_rs;
  - else 00. fwd_b is identical with ex_rt. EX/MEM beats MEM/WB.
- Reset (synchronous): all stage registers are 0, so every registered output is 0, fwd_a/fwd_b=00, stall=0. flush_ifid=0 unless the current inputs demand it. Reset mid-stream discards all in-flight controls in one edge; no writes issue after rst is sampled.
- Register 0 is never a hazard or forward source.

Decomposition:
- Shared package pipe_ctrl_pkg holds: opcode constants (OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LW, OP_SW); ALUOp constants (ALU_ADD=000, ALU_SUB=001, ALU_FUNCT=010, ALU_AND=011, ALU_OR=100, ALU_SLT=101); the packed control-bundle typedef; and the FWD_* select constants.
- One sub-module, ctrl_decode, holds the combinational opcode→bundle table. Stage registers, hazard and forwarding logic stay in pipe_control.

Test Plan:
- Reset: rst=1 for 2 cycles with id_opcode=R-type → all stage outputs 0, stall=0. Release rst → first R bundle reaches wb_reg_write=1 exactly 3 edges later.
- Load-use: lw $2 then add $3,$2,$4 → stall=1 for exactly 1 cycle. Next cycle ex_* is the bubble (ex_wreg=0), then add proceeds and fwd_a=01 in its EX cycle.
- Forwarding: add $5 then sub $6,$5,$5 back-to-back → fwd_a=fwd_b=10. Writes to $0 → fwd stays 00.
- Branch: beq in EX with ex_branch_taken=1 while a load-use hazard exists in ID → flush_ifid=1, stall=0, next ex_* bundle all-zero.
- Jump: id_opcode=000010 → id_jump=1, flush_ifid=1. Three cycles later wb_reg_write=0 and mem_write never set.
- Decode sweep: every table opcode checked field by field. Opcode 111111 → id_illegal=1, zero bundle propagates, no reg/mem write.
